fe_frame_parser: RTL and testbench
==================================

Name: fe_frame_parser

Overview:
- Parametrised successor to the front-end byte parser behind the UART receiver.
- Accepts received bytes (rok/mosi) and decodes each frame as: command byte, big-endian length field of LEN_BYTES bytes, payload, and an optional XOR checksum byte.
- Forwards payload bytes with a last flag, reports header, checksum and timeout events, and generates fe_done from the FIFO-side done level.
- Sits between the UART RX byte stream and the command/FIFO control logic.

Parameters:
- LEN_BYTES, 2, number of length-field bytes, legal range 1..4; rx_cnt width LW = 8*LEN_BYTES.
- CHK_EN, 0, 1 = frame carries a trailing XOR checksum byte.
- TIMEOUT_CYC, 65535, maximum idle cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rok  in  1  mosi valid for one cycle.
- mosi  in  8  received byte.
- fifo_done  in  1  level from FIFO control; high = current transfer complete/abort.
- cmd  out  8  latched command byte.
- rx_cnt  out  LW  latched payload length.
- hdr_valid  out  1  one-cycle pulse when the header is complete.
- pay_valid  out  1  payload byte strobe.
- pay_data  out  8  payload byte.
- pay_last  out  1  with pay_valid, marks the final payload byte.
- busy  out  1  high in any state other than S_CMD.
- chk_err  out  1  one-cycle pulse on checksum mismatch.
- tmo_err  out  1  one-cycle pulse on inter-byte timeout.
- fe_done  out  1  one-cycle pulse on the falling edge of fifo_done.

Behaviour:
- Reset (clk edge with rst=1): state=S_CMD. cmd=0, rx_cnt=0, all pulse outputs 0, pay_data=0, busy=0, sync flops=0, counters=0, checksum accumulator=0. Reset mid-frame discards the frame with no error pulses.
- Single clock; all outputs registered.
- States: S_CMD, S_LEN, S_PAY, S_CHK, S_WAIT.
- S_CMD: on rok, cmd<=mosi, chk<=mosi, byte index<=0, go to S_LEN.
- S_LEN: each rok shifts rx_cnt<={rx_cnt[LW-9:0],mosi} (MSB byte first) and XORs mosi into chk. On the LEN_BYTES-th byte, hdr_valid pulses the next cycle (same edge that updates rx_cnt to its final value) and the remaining counter loads the full length. Next state: length != 0 goes to S_PAY; length = 0 goes to S_CHK if CHK_EN, else S_WAIT.
- S_PAY: each rok gives pay_valid=1 and pay_data=mosi one cycle later (latency 1), XORs into chk, and decrements remaining. pay_last=1 when remaining==1 before the decrement. After the last byte, go to S_CHK if CHK_EN, else S_WAIT. The remaining counter is LW bits, so max length 2^LW-1 with no wrap.
- S_CHK: on rok, if mosi != chk, chk_err pulses the next cycle. Go to S_WAIT either way.
- S_WAIT: ignore rok. When fifo_done=1, go to S_CMD.
- fifo_done=1 in S_LEN/S_PAY/S_CHK aborts to S_CMD. If rok arrives in the same cycle, fifo_done wins and the byte is dropped (no pay_valid). cmd and rx_cnt hold their last values until the next frame overwrites them.
- Timeout: the idle counter clears on every rok and counts while in S_LEN/S_PAY/S_CHK. When it reaches TIMEOUT_CYC, tmo_err pulses, the state returns to S_CMD, and any partial payload is not flagged last. The counter does not run in S_CMD or S_WAIT.
- fe_done: fifo_done passes through a 3-flop chain d1->d2->d3, and fe_done = d3 & ~d2. This is a pulse 3 cycles after fifo_done falls; a 1-cycle fifo_done high still yields exactly one pulse. Independent of the FSM state.
- Simultaneous events on one edge: rst overrides everything; then fifo_done abort; then timeout; then rok.

Decomposition:
- Shared package fe_pkg: state encoding constants (S_CMD..S_WAIT), CMD_W=8, LEN_BYTES_MAX=4.
- One sub-module: fe_edge_sync (3-flop chain plus falling-edge pulse), reused by other front-end blocks.

Test Plan:
- LEN_BYTES=2, CHK_EN=0; bytes 0xA5,0x00,0x03,0x11,0x22,0x33 -> cmd=0xA5, rx_cnt=0x0003, one hdr_valid, three pay_valid with data 11/22/33, pay_last only on 0x33, busy until fifo_done.
- CHK_EN=1; frame 0x10,0x00,0x01,0x20, chk 0x31 -> no chk_err. Repeat with chk 0x30 -> chk_err pulse one cycle after the checksum byte.
- Zero length 0x05,0x00,0x00 -> hdr_valid, no pay_valid, state goes straight to S_WAIT (or S_CHK when CHK_EN=1).
- TIMEOUT_CYC=16; send cmd plus one length byte, then idle 16 cycles -> tmo_err pulse, busy=0. Next 0x07,0x00,0x01,0xEE is parsed cleanly.
- fifo_done pulse in S_PAY together with rok -> byte dropped, state S_CMD, fe_done pulses 3 cycles after fifo_done falls. rst asserted mid-payload -> all outputs return to reset values next cycle.
- LEN_BYTES=4 with length 0x00000102 -> 258 payload bytes, pay_last on byte 258; LEN_BYTES=1 with length 0xFF -> 255 bytes.

Source files
------------

// File: rtl/fe_pkg.sv
`default_nettype none
// ============================================================================
//  fe_pkg : shared types and constants for the UART front-end blocks
//  Rev 1.0
// ============================================================================
package fe_pkg;

    localparam int CMD_W         = 8;
    localparam int LEN_BYTES_MAX = 4;

    typedef enum logic [2:0] {
        S_CMD  = 3'd0,
        S_LEN  = 3'd1,
        S_PAY  = 3'd2,
        S_CHK  = 3'd3,
        S_WAIT = 3'd4
    } fe_state_t;

endpackage
`default_nettype wire

// File: rtl/fe_edge_sync.sv
`default_nettype none
// ============================================================================
//  fe_edge_sync : 3-flop synchroniser with a one-cycle falling-edge pulse
//  Rev 1.0
// ============================================================================
module fe_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall
);

    logic d1;
    logic d2;
    logic d3;

    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
            d3 <= 1'b0;
        end else begin
            d1 <= din;
            d2 <= d1;
            d3 <= d2;
        end
    end

    assign fall = d3 & ~d2;

endmodule
`default_nettype wire

// File: rtl/fe_frame_parser.sv
`default_nettype none
// ============================================================================
//  fe_frame_parser : cmd / length / payload / optional XOR checksum decoder
//  Rev 1.0
// ============================================================================
module fe_frame_parser
    import fe_pkg::*;
#(
    parameter int LEN_BYTES   = 2,
    parameter int CHK_EN      = 0,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rok,
    input  logic [7:0]               mosi,
    input  logic                     fifo_done,
    output logic [CMD_W-1:0]         cmd,
    output logic [8*LEN_BYTES-1:0]   rx_cnt,
    output logic                     hdr_valid,
    output logic                     pay_valid,
    output logic [7:0]               pay_data,
    output logic                     pay_last,
    output logic                     busy,
    output logic                     chk_err,
    output logic                     tmo_err,
    output logic                     fe_done
);

    localparam int LW = 8 * LEN_BYTES;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int IW = $clog2(LEN_BYTES_MAX);
    localparam bit TMO_EN = (TIMEOUT_CYC != 0);
    localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST = IW'(LEN_BYTES - 1);
    localparam fe_state_t TAIL = (CHK_EN != 0) ? S_CHK : S_WAIT;

    fe_state_t       state;
    logic [IW-1:0]   idx;
    logic [LW-1:0]   remaining;
    logic [7:0]      chk;
    logic [TW-1:0]   idle;
    logic [LW+7:0]   len_shift;
    logic [LW-1:0]   len_next;
    logic            active;
    logic            timeout;

    // Shift through a widened vector so LEN_BYTES=1 needs no empty slice
    assign len_shift = {rx_cnt, mosi};
    assign len_next  = len_shift[LW-1:0];
    assign active    = (state == S_LEN) || (state == S_PAY) || (state == S_CHK);
    assign timeout   = TMO_EN && active && !rok && (idle == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CMD;
            cmd       <= '0;
            rx_cnt    <= '0;
            hdr_valid <= 1'b0;
            pay_valid <= 1'b0;
            pay_data  <= '0;
            pay_last  <= 1'b0;
            busy      <= 1'b0;
            chk_err   <= 1'b0;
            tmo_err   <= 1'b0;
            idx       <= '0;
            remaining <= '0;
            chk       <= '0;
            idle      <= '0;
        end else begin
            hdr_valid <= 1'b0;
            pay_valid <= 1'b0;
            pay_last  <= 1'b0;
            chk_err   <= 1'b0;
            tmo_err   <= 1'b0;
            idle      <= (active && !rok) ? idle + 1'b1 : '0;

            if (fifo_done && state != S_CMD) begin
                state <= S_CMD;
                busy  <= 1'b0;
            end else if (timeout) begin
                state   <= S_CMD;
                busy    <= 1'b0;
                tmo_err <= 1'b1;
                idle    <= '0;
            end else if (rok) begin
                case (state)
                    S_CMD: begin
                        cmd   <= mosi;
                        chk   <= mosi;
                        idx   <= '0;
                        state <= S_LEN;
                        busy  <= 1'b1;
                    end
                    S_LEN: begin
                        rx_cnt <= len_next;
                        chk    <= chk ^ mosi;
                        idx    <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            hdr_valid <= 1'b1;
                            remaining <= len_next;
                            state     <= (len_next != '0) ? S_PAY : TAIL;
                        end
                    end
                    S_PAY: begin
                        pay_valid <= 1'b1;
                        pay_data  <= mosi;
                        chk       <= chk ^ mosi;
                        remaining <= remaining - 1'b1;
                        if (remaining == LW'(1)) begin
                            pay_last <= 1'b1;
                            state    <= TAIL;
                        end
                    end
                    S_CHK: begin
                        chk_err <= (mosi != chk);
                        state   <= S_WAIT;
                    end
                    S_WAIT: begin
                    end
                    default: begin
                        state <= S_CMD;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    fe_edge_sync u_done_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (fifo_done),
        .fall (fe_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_fe_frame_parser.sv
`default_nettype none
// ============================================================================
//  tb_fe_frame_parser : directed checks over four parameterisations
//  Rev 1.0
// ============================================================================
module tb_fe_frame_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_done;
    logic [3:0]  rok;
    logic [7:0]  mosi;

    logic [7:0]  cmd_o [4];
    logic [7:0]  pdat  [4];
    logic [3:0]  hdr, pv, pl, bsy, cerr, terr, fdone;
    logic [15:0] rx0, rx1;
    logic [31:0] rx2;
    logic [7:0]  rx3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: LEN=2 no chk tmo=16 | 1: LEN=2 chk tmo=16 | 2: LEN=4 | 3: LEN=1
    fe_frame_parser #(.LEN_BYTES(2), .CHK_EN(0), .TIMEOUT_CYC(16)) u0 (
        .clk(clk), .rst(rst), .rok(rok[0]), .mosi(mosi), .fifo_done(fifo_done),
        .cmd(cmd_o[0]), .rx_cnt(rx0), .hdr_valid(hdr[0]), .pay_valid(pv[0]),
        .pay_data(pdat[0]), .pay_last(pl[0]), .busy(bsy[0]), .chk_err(cerr[0]),
        .tmo_err(terr[0]), .fe_done(fdone[0]));
    fe_frame_parser #(.LEN_BYTES(2), .CHK_EN(1), .TIMEOUT_CYC(16)) u1 (
        .clk(clk), .rst(rst), .rok(rok[1]), .mosi(mosi), .fifo_done(fifo_done),
        .cmd(cmd_o[1]), .rx_cnt(rx1), .hdr_valid(hdr[1]), .pay_valid(pv[1]),
        .pay_data(pdat[1]), .pay_last(pl[1]), .busy(bsy[1]), .chk_err(cerr[1]),
        .tmo_err(terr[1]), .fe_done(fdone[1]));
    fe_frame_parser #(.LEN_BYTES(4), .CHK_EN(0), .TIMEOUT_CYC(0)) u2 (
        .clk(clk), .rst(rst), .rok(rok[2]), .mosi(mosi), .fifo_done(fifo_done),
        .cmd(cmd_o[2]), .rx_cnt(rx2), .hdr_valid(hdr[2]), .pay_valid(pv[2]),
        .pay_data(pdat[2]), .pay_last(pl[2]), .busy(bsy[2]), .chk_err(cerr[2]),
        .tmo_err(terr[2]), .fe_done(fdone[2]));
    fe_frame_parser #(.LEN_BYTES(1), .CHK_EN(0), .TIMEOUT_CYC(0)) u3 (
        .clk(clk), .rst(rst), .rok(rok[3]), .mosi(mosi), .fifo_done(fifo_done),
        .cmd(cmd_o[3]), .rx_cnt(rx3), .hdr_valid(hdr[3]), .pay_valid(pv[3]),
        .pay_data(pdat[3]), .pay_last(pl[3]), .busy(bsy[3]), .chk_err(cerr[3]),
        .tmo_err(terr[3]), .fe_done(fdone[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [7:0] b);
        mosi   = b;
        rok[s] = 1'b1;
        tick();
        rok    = '0;
    endtask

    task automatic done_pulse();
        fifo_done = 1'b1;
        tick();
        fifo_done = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int npv, nlast, last_at;
        rst = 1'b1; fifo_done = 1'b0; rok = '0; mosi = '0;
        tick(); tick();
        check("rst_cmd",   {24'd0, cmd_o[0]}, 32'h0);
        check("rst_rx",    {16'd0, rx0}, 32'h0);
        check("rst_busy",  {28'd0, bsy}, 32'h0);
        check("rst_pv",    {28'd0, pv}, 32'h0);
        check("rst_done",  {28'd0, fdone}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic frame, LEN=2
        send(0, 8'hA5);
        check("f1_busy",   {31'd0, bsy[0]}, 32'h1);
        check("f1_hdr0",   {31'd0, hdr[0]}, 32'h0);
        send(0, 8'h00);
        send(0, 8'h03);
        check("f1_hdr",    {31'd0, hdr[0]}, 32'h1);
        check("f1_cmd",    {24'd0, cmd_o[0]}, 32'hA5);
        check("f1_rx",     {16'd0, rx0}, 32'h3);
        send(0, 8'h11);
        check("f1_p1",     {23'd0, pv[0], pl[0], pdat[0]}, {23'd0, 1'b1, 1'b0, 8'h11});
        check("f1_hdr1",   {31'd0, hdr[0]}, 32'h0);
        send(0, 8'h22);
        check("f1_p2",     {23'd0, pv[0], pl[0], pdat[0]}, {23'd0, 1'b1, 1'b0, 8'h22});
        send(0, 8'h33);
        check("f1_p3",     {23'd0, pv[0], pl[0], pdat[0]}, {23'd0, 1'b1, 1'b1, 8'h33});
        tick();
        check("f1_idle",   {30'd0, pv[0], bsy[0]}, 32'h1);
        send(0, 8'h99);
        check("f1_wait",   {30'd0, pv[0], bsy[0]}, 32'h1);
        done_pulse();
        check("f1_free",   {31'd0, bsy[0]}, 32'h0);
        tick();
        check("fd_e1",     {31'd0, fdone[0]}, 32'h0);
        tick();
        check("fd_e2",     {31'd0, fdone[0]}, 32'h1);
        tick();
        check("fd_e3",     {31'd0, fdone[0]}, 32'h0);

        // Checksum good then bad
        send(1, 8'h10); send(1, 8'h00); send(1, 8'h01);
        check("c1_hdr",    {31'd0, hdr[1]}, 32'h1);
        send(1, 8'h20);
        check("c1_last",   {30'd0, pv[1], pl[1]}, 32'h3);
        send(1, 8'h31);
        check("c1_ok",     {30'd0, cerr[1], bsy[1]}, 32'h1);
        done_pulse();
        send(1, 8'h10); send(1, 8'h00); send(1, 8'h01); send(1, 8'h20);
        send(1, 8'h30);
        check("c2_err",    {31'd0, cerr[1]}, 32'h1);
        tick();
        check("c2_pulse",  {31'd0, cerr[1]}, 32'h0);
        done_pulse();

        // Zero length
        send(0, 8'h05); send(0, 8'h00); send(0, 8'h00);
        check("z0_hdr",    {30'd0, hdr[0], bsy[0]}, 32'h3);
        check("z0_rx",     {16'd0, rx0}, 32'h0);
        send(0, 8'h44);
        check("z0_nopay",  {30'd0, pv[0], bsy[0]}, 32'h1);
        done_pulse();
        send(1, 8'h05); send(1, 8'h00); send(1, 8'h00);
        check("z1_hdr",    {31'd0, hdr[1]}, 32'h1);
        send(1, 8'h06);
        check("z1_chk",    {30'd0, pv[1], cerr[1]}, 32'h1);
        done_pulse();

        // Timeout after one of two length bytes
        send(0, 8'h07); send(0, 8'h00);
        for (int i = 0; i < 15; i++) tick();
        check("t_before",  {30'd0, terr[0], bsy[0]}, 32'h1);
        tick();
        check("t_fire",    {30'd0, terr[0], bsy[0]}, 32'h2);
        tick();
        check("t_pulse",   {31'd0, terr[0]}, 32'h0);
        send(0, 8'h07); send(0, 8'h00); send(0, 8'h01);
        check("t_hdr",     {15'd0, hdr[0], rx0}, {15'd0, 1'b1, 16'h0001});
        send(0, 8'hEE);
        check("t_pay",     {23'd0, pv[0], pl[0], pdat[0]}, {23'd0, 1'b1, 1'b1, 8'hEE});
        done_pulse();

        // Abort with coincident rok
        send(0, 8'h07); send(0, 8'h00); send(0, 8'h02); send(0, 8'hAA);
        check("a_p1",      {31'd0, pv[0]}, 32'h1);
        fifo_done = 1'b1;
        send(0, 8'hBB);
        fifo_done = 1'b0;
        check("a_drop",    {30'd0, pv[0], bsy[0]}, 32'h0);
        check("a_hold",    {8'd0, cmd_o[0], rx0}, {8'd0, 8'h07, 16'h0002});
        tick();
        check("a_fd1",     {31'd0, fdone[0]}, 32'h0);
        tick();
        check("a_fd2",     {31'd0, fdone[0]}, 32'h1);

        // Reset mid-payload
        send(0, 8'h09); send(0, 8'h00); send(0, 8'h03); send(0, 8'hAB);
        check("r_pay",     {23'd0, pv[0], bsy[0], pdat[0]}, {23'd0, 1'b1, 1'b1, 8'hAB});
        rst = 1'b1;
        tick();
        check("r_cmd",     {8'd0, cmd_o[0], rx0}, 32'h0);
        check("r_out",     {22'd0, pv[0], pl[0], bsy[0], hdr[0], pdat[0]}, 32'h0);
        rst = 1'b0;
        tick();

        // LEN_BYTES=4, 258 bytes
        send(2, 8'h33); send(2, 8'h00); send(2, 8'h00); send(2, 8'h01); send(2, 8'h02);
        check("l4_hdr",    {31'd0, hdr[2]}, 32'h1);
        check("l4_rx",     rx2, 32'h00000102);
        npv = 0; nlast = 0; last_at = -1;
        for (int i = 0; i < 258; i++) begin
            send(2, 8'(i));
            if (pv[2]) npv++;
            if (pl[2]) begin nlast++; last_at = i; end
        end
        check("l4_npv",    npv, 258);
        check("l4_nlast",  nlast, 1);
        check("l4_lastat", last_at, 257);
        check("l4_data",   {24'd0, pdat[2]}, 32'h01);
        done_pulse();

        // LEN_BYTES=1, 255 bytes
        send(3, 8'h44); send(3, 8'hFF);
        check("l1_rx",     {23'd0, hdr[3], rx3}, {23'd0, 1'b1, 8'hFF});
        npv = 0; nlast = 0; last_at = -1;
        for (int i = 0; i < 255; i++) begin
            send(3, 8'(i + 1));
            if (pv[3]) npv++;
            if (pl[3]) begin nlast++; last_at = i; end
        end
        check("l1_npv",    npv, 255);
        check("l1_lastat", last_at, 254);
        check("l1_nlast",  nlast, 1);
        tick();
        check("l1_busy",   {30'd0, pv[3], bsy[3]}, 32'h1);
        done_pulse();
        check("l1_free",   {31'd0, bsy[3]}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
